// File: rtl/conv_x_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_x_ctrl
// Brief    : x-stream window sequencer for the convolution datapath. Fills the
//            x shift memory, starts the MAC once a window is resident, then
//            hands y downstream. Optional macro CONV_X_OVERLAP_EN lets the
//            next x sample be accepted while y waits downstream.
// Revision : 1.0  initial release
// ============================================================================
module conv_x_ctrl #(
    parameter int WIDTH  = 16,
    parameter int SIZE   = 64,
    parameter int LEN_X  = 128,
    parameter int LOGLEN = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  s_data_x,
    input  logic              s_valid_x,
    output logic              s_ready_x,
    output logic [WIDTH-1:0]  x_wr_data,
    output logic              x_wr_en,
    output logic              mac_start,
    input  logic              mac_done,
    output logic              m_valid_y,
    input  logic              m_ready_y,
    output logic [LOGLEN-1:0] win_idx
);

    localparam logic [LOGLEN-1:0] c_win_taps = LOGLEN'(SIZE + 1);
    localparam logic [LOGLEN-1:0] c_len_x    = LOGLEN'(LEN_X);
    localparam logic [LOGLEN-1:0] c_one      = LOGLEN'(1);

    typedef enum logic [2:0] {
        S_FILL  = 3'd0,
        S_START = 3'd1,
        S_MAC   = 3'd2,
        S_OUT   = 3'd3,
        S_PEND  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [LOGLEN-1:0] cnt_q, cnt_d;
    logic [LOGLEN-1:0] win_idx_q, win_idx_d;
    logic [LOGLEN-1:0] cnt_inc;
    logic              accept;
    logic              cnt_at_end;

    assign cnt_inc    = cnt_q + c_one;
    assign cnt_at_end = (cnt_q == c_len_x);

    // Handshake outputs are decoded from state only; reset forces them low.
    always_comb begin
        s_ready_x = 1'b0;
        mac_start = 1'b0;
        m_valid_y = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FILL:  s_ready_x = 1'b1;
                S_START: mac_start = 1'b1;
                S_OUT: begin
                    m_valid_y = 1'b1;
`ifdef CONV_X_OVERLAP_EN
                    // Never take a sample belonging to the next vector here.
                    s_ready_x = (cnt_q < c_len_x);
`endif
                end
                S_PEND:  m_valid_y = 1'b1;
                default: ;
            endcase
        end
    end

    assign accept    = s_valid_x & s_ready_x;
    assign x_wr_en   = accept;
    assign x_wr_data = s_data_x;
    assign win_idx   = win_idx_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_idx_d = win_idx_q;
        if (accept) begin
            cnt_d = cnt_inc;
        end
        case (state_q)
            S_FILL: begin
                if (accept && (cnt_inc >= c_win_taps)) begin
                    state_d = S_START;
                end
            end
            S_START: state_d = S_MAC;
            S_MAC: begin
                if (mac_done) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (m_ready_y) begin
                    if (cnt_at_end) begin
                        // Vector complete: the next window needs a full refill.
                        cnt_d     = '0;
                        win_idx_d = '0;
                        state_d   = S_FILL;
                    end else begin
                        win_idx_d = win_idx_q + c_one;
                        state_d   = accept ? S_START : S_FILL;
                    end
                end
`ifdef CONV_X_OVERLAP_EN
                else if (accept) begin
                    state_d = S_PEND;
                end
`endif
            end
`ifdef CONV_X_OVERLAP_EN
            S_PEND: begin
                if (m_ready_y) begin
                    win_idx_d = win_idx_q + c_one;
                    state_d   = S_START;
                end
            end
`endif
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FILL;
            cnt_q     <= '0;
            win_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_idx_q <= win_idx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_x_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_x_ctrl
// Brief    : directed self-checking bench for conv_x_ctrl (SIZE=3, LEN_X=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_conv_x_ctrl;

    localparam int WIDTH  = 16;
    localparam int SIZE   = 3;
    localparam int LEN_X  = 8;
    localparam int LOGLEN = 4;
    localparam int NWIN   = LEN_X - SIZE;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic [WIDTH-1:0]  s_data_x  = '0;
    logic              s_valid_x = 1'b0;
    logic              s_ready_x;
    logic [WIDTH-1:0]  x_wr_data;
    logic              x_wr_en;
    logic              mac_start;
    logic              mac_done;
    logic              model_done = 1'b0;
    logic              spur_done  = 1'b0;
    logic              m_valid_y;
    logic              m_ready_y  = 1'b1;
    logic [LOGLEN-1:0] win_idx;

    assign mac_done = model_done | spur_done;

    conv_x_ctrl #(
        .WIDTH  (WIDTH),
        .SIZE   (SIZE),
        .LEN_X  (LEN_X),
        .LOGLEN (LOGLEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_data_x  (s_data_x),
        .s_valid_x (s_valid_x),
        .s_ready_x (s_ready_x),
        .x_wr_data (x_wr_data),
        .x_wr_en   (x_wr_en),
        .mac_start (mac_start),
        .mac_done  (mac_done),
        .m_valid_y (m_valid_y),
        .m_ready_y (m_ready_y),
        .win_idx   (win_idx)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- observation ----------------
    int wr_cnt, ms_cnt, y_cnt, stall_cyc, follow_cnt, ovl_acc, pend_seen;
    int vec_acc = 0, vec_y = 0, acc4_cyc = 0, last_hs_cyc = -10;
    bit expect_first = 0, prev_hold = 0, prev_ovl = 0;
    logic [LOGLEN-1:0] prev_idx = '0;
    int y_idx_q[$];
    int wr_q[$];

    always @(negedge clk) begin
        if (reset) begin
            vec_acc = 0; vec_y = 0; expect_first = 0; prev_hold = 0; prev_ovl = 0;
        end else begin
            if (prev_hold) begin
                chk("y_hold_valid", 32'(m_valid_y), 1);
                chk("y_hold_idx", 32'(win_idx), 32'(prev_idx));
            end
            if (prev_ovl && m_valid_y && !s_ready_x) pend_seen++;
            if (x_wr_en) begin
                chk("wr_needs_valid", 32'(s_valid_x), 1);
                wr_cnt++;
                wr_q.push_back(int'(x_wr_data));
                if (m_valid_y) ovl_acc++;
                vec_acc++;
                if (vec_acc == SIZE + 1) begin
                    acc4_cyc = cyc;
                    expect_first = 1;
                end
            end
            if (mac_start) begin
                ms_cnt++;
                chk("start_after_fill", 32'(vec_acc >= SIZE + 1), 1);
                if (expect_first) begin
                    chk("first_start_lat", 32'(cyc - acc4_cyc), 1);
                    expect_first = 0;
                end
                if (cyc == last_hs_cyc + 1) follow_cnt++;
            end
            if (m_valid_y && !m_ready_y) stall_cyc++;
            if (m_valid_y && m_ready_y) begin
                y_cnt++;
                y_idx_q.push_back(int'(win_idx));
                last_hs_cyc = cyc;
                vec_y++;
                if (vec_y == NWIN) begin
                    vec_y = 0;
                    vec_acc = 0;
                end
            end
            prev_ovl  = m_valid_y && x_wr_en && !m_ready_y;
            prev_hold = m_valid_y && !m_ready_y;
            prev_idx  = win_idx;
        end
    end

    // MAC model: done pulse two cycles after the start pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (mac_start && !reset) begin
                @(posedge clk);
                @(posedge clk);
                #1 model_done = 1'b1;
                @(posedge clk);
                #1 model_done = 1'b0;
            end
        end
    end

    // Downstream: 0 = always ready, 1 = stall window 2 for 5 cycles, 2 = stall each y 3 cycles.
    int rdy_mode = 0;
    int wait_cnt = 0;
    int need     = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (m_valid_y) begin
                need = (rdy_mode == 2) ? 3 : ((rdy_mode == 1 && win_idx == 2) ? 5 : 0);
                m_ready_y = (wait_cnt >= need);
                wait_cnt  = m_ready_y ? 0 : wait_cnt + 1;
            end else begin
                m_ready_y = (rdy_mode == 0);
                wait_cnt  = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit toggle = 0;

    task automatic push(input int data);
        bit acc;
        acc = 0;
        s_valid_x = 1'b1;
        s_data_x  = WIDTH'(data);
        for (int n = 0; n < 300 && !acc; n++) begin
            @(negedge clk);
            acc = s_ready_x;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("push_timeout", 0, 1);
        s_valid_x = 1'b0;
        if (toggle) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_range(input int first, input int n);
        for (int i = 0; i < n; i++) push(first + i);
    endtask

    task automatic wait_y(input int n);
        for (int i = 0; i < 3000 && y_cnt < n; i++) begin
            @(posedge clk);
            #1;
        end
        chk("y_count", 32'(y_cnt), 32'(n));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        wr_cnt = 0; ms_cnt = 0; y_cnt = 0; stall_cyc = 0;
        follow_cnt = 0; ovl_acc = 0; pend_seen = 0;
        y_idx_q.delete();
        wr_q.delete();
    endtask

    task automatic check_run(input int nvec, input int first);
        chk("y_q_size", 32'(y_idx_q.size()), 32'(nvec * NWIN));
        for (int i = 0; i < y_idx_q.size(); i++)
            chk("win_idx_seq", 32'(y_idx_q[i]), 32'(i % NWIN));
        chk("wr_en_count", 32'(wr_cnt), 32'(nvec * LEN_X));
        for (int i = 0; i < wr_q.size(); i++)
            chk("wr_data", 32'(wr_q[i]), 32'(first + i));
        chk("mac_start_count", 32'(ms_cnt), 32'(nvec * NWIN));
        chk("idx_after_vector", 32'(win_idx), 0);
    endtask

    task automatic do_reset(input int ncyc);
        reset = 1'b1;
        s_valid_x = 1'b1;
        repeat (ncyc) begin
            @(negedge clk);
            chk("rst_ready", 32'(s_ready_x), 0);
            chk("rst_wr_en", 32'(x_wr_en), 0);
            chk("rst_mac_start", 32'(mac_start), 0);
            chk("rst_valid_y", 32'(m_valid_y), 0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        s_valid_x = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(s_ready_x), 1);
        chk("post_rst_valid_y", 32'(m_valid_y), 0);
        chk("post_rst_idx", 32'(win_idx), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        clear_stats();
        do_reset(2);

        // 1: back-to-back vector, downstream always ready
        clear_stats();
        push_range(1, LEN_X);
        wait_y(NWIN);
        check_run(1, 1);
`ifndef CONV_X_OVERLAP_EN
        chk("t1_no_overlap_start", 32'(follow_cnt), 0);
`endif

        // 2: stall window 2 for five cycles
        clear_stats();
        rdy_mode = 1;
        push_range(1, LEN_X);
        wait_y(NWIN);
        check_run(1, 1);
        chk("t2_stall_cycles", 32'(stall_cyc), 5);
`ifndef CONV_X_OVERLAP_EN
        chk("t2_no_wr_while_y", 32'(ovl_acc), 0);
`endif
        rdy_mode = 0;

        // 3: x valid alternating
        clear_stats();
        toggle = 1;
        push_range(1, LEN_X);
        wait_y(NWIN);
        check_run(1, 1);
        toggle = 0;

        // 4: reset during the MAC of window 1, spurious mac_done, then a fresh vector
        clear_stats();
        push_range(1, SIZE + 2);
        for (int i = 0; i < 200 && ms_cnt < 2; i++) begin
            @(posedge clk);
            #1;
        end
        chk("t4_second_start", 32'(ms_cnt), 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t4_idx_cleared", 32'(win_idx), 0);
        chk("t4_ready_fill", 32'(s_ready_x), 1);
        @(posedge clk);
        #1 spur_done = 1'b1;
        @(posedge clk);
        #1 spur_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t4_spurious_valid", 32'(m_valid_y), 0);
            chk("t4_spurious_start", 32'(mac_start), 0);
        end
        @(posedge clk);
        #1;
        clear_stats();
        push_range(11, LEN_X);
        wait_y(NWIN);
        check_run(1, 11);

        // 5: two vectors back-to-back
        clear_stats();
        push_range(1, 2 * LEN_X);
        wait_y(2 * NWIN);
        check_run(2, 1);

`ifdef CONV_X_OVERLAP_EN
        // 6: overlap, three-cycle stall on every y
        clear_stats();
        rdy_mode = 2;
        push_range(1, LEN_X);
        wait_y(NWIN);
        check_run(1, 1);
        chk("t6_overlap_accepts", 32'(ovl_acc), 4);
        chk("t6_pend_seen", 32'(pend_seen), 4);
        chk("t6_start_after_hs", 32'(follow_cnt), 4);
        chk("t6_stall_cycles", 32'(stall_cyc), 15);
        rdy_mode = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
